// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory access sequencer: access sizes, FSM states
// and grant identifiers, plus the request legality check.
package mem_arbiter_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IRESP = 2'd1;
    localparam logic [1:0] S_DRESP = 2'd2;
    localparam logic [1:0] S_RMW   = 2'd3;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    // Size/offset combinations the memory port cannot serve in one word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == 2'b11) ||
               (size == SIZE_H && offset[0]) ||
               (size == SIZE_W && offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte/halfword lane logic: extracts and extends load data, and merges store
// data into a read word for read-modify-write. Purely combinational.
module mem_lane
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       size,
    input  logic [1:0]       offset,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] merged
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] mask;

    // Lane select, extension and merge mask, little-endian byte order.
    always_comb begin
        shamt     = '0;
        mask      = '1;
        load_data = rdata;
        if (size == SIZE_B) begin
            shamt = SW'({offset, 3'b000});
        end else if (size == SIZE_H) begin
            shamt = SW'({offset[1], 4'b0000});
        end
        lane = rdata >> shamt;
        unique case (size)
            SIZE_B: begin
                load_data = {{(WIDTH-8){lane[7] & ~is_unsigned}}, lane[7:0]};
                mask      = WIDTH'(8'hFF) << shamt;
            end
            SIZE_H: begin
                load_data = {{(WIDTH-16){lane[15] & ~is_unsigned}}, lane[15:0]};
                mask      = WIDTH'(16'hFFFF) << shamt;
            end
            default: begin
                load_data = rdata;
                mask      = '1;
            end
        endcase
        merged = (rdata & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer: round-robin arbitration between fetch and
// load/store, one word request per cycle, sub-word stores via read-modify-write.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEV_BASE   = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ireq_valid_i,
    output logic                  ireq_ready_o,
    input  logic [ADDR_WIDTH-1:0] ireq_addr_i,
    output logic                  iresp_valid_o,
    output logic [WIDTH-1:0]      iresp_data_o,
    input  logic                  dreq_valid_i,
    output logic                  dreq_ready_o,
    input  logic                  dreq_we_i,
    input  logic [1:0]            dreq_size_i,
    input  logic                  dreq_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] dreq_addr_i,
    input  logic [WIDTH-1:0]      dreq_wdata_i,
    output logic                  dresp_valid_o,
    output logic [WIDTH-1:0]      dresp_rdata_o,
    output logic                  dresp_err_o,
    output logic                  memread_o,
    output logic                  memwrite_o,
    output logic [ADDR_WIDTH-1:0] memaddr_o,
    output logic [WIDTH-1:0]      memwdata_o,
    input  logic [WIDTH-1:0]      memrdata_i
);

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic                  uns_q;
    logic                  is_load_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;

    logic                  can_accept;
    logic                  fetch_win;
    logic                  data_win;
    logic                  d_err;
    logic [ADDR_WIDTH-1:0] i_word_addr;
    logic [ADDR_WIDTH-1:0] d_word_addr;
    logic [WIDTH-1:0]      load_data;
    logic [WIDTH-1:0]      merged;
    logic                  unused_fetch_offset;

    // Fetches are always word-aligned by the core; low bits are ignored.
    assign unused_fetch_offset = ^ireq_addr_i[1:0];

    assign i_word_addr = {ireq_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign d_word_addr = {dreq_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Arbitration: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        can_accept = !rst && (state_q != S_RMW);
        fetch_win  = can_accept && ireq_valid_i &&
                     (!dreq_valid_i || last_grant_q == GRANT_DATA);
        data_win   = can_accept && dreq_valid_i && !fetch_win;
        d_err      = is_misaligned(dreq_size_i, dreq_addr_i[1:0]) ||
                     (dreq_we_i && dreq_size_i != SIZE_W &&
                      dreq_addr_i >= ADDR_WIDTH'(DEV_BASE));
    end

    // Lane logic always works on captured request attributes and the read word.
    mem_lane #(
        .WIDTH (WIDTH)
    ) u_lane (
        .rdata       (memrdata_i),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Next state, responses and memory strobes; everything is forced low during rst.
    always_comb begin
        state_d       = state_q;
        ireq_ready_o  = 1'b0;
        dreq_ready_o  = 1'b0;
        iresp_valid_o = 1'b0;
        iresp_data_o  = '0;
        dresp_valid_o = 1'b0;
        dresp_rdata_o = '0;
        dresp_err_o   = 1'b0;
        memread_o     = 1'b0;
        memwrite_o    = 1'b0;
        memaddr_o     = '0;
        memwdata_o    = '0;
        if (!rst) begin
            unique case (state_q)
                S_IRESP: begin
                    iresp_valid_o = 1'b1;
                    iresp_data_o  = memrdata_i;
                    state_d       = S_IDLE;
                end
                S_DRESP: begin
                    dresp_valid_o = 1'b1;
                    dresp_err_o   = err_q;
                    dresp_rdata_o = (is_load_q && !err_q) ? load_data : '0;
                    state_d       = S_IDLE;
                end
                S_RMW: begin
                    memwrite_o = 1'b1;
                    memaddr_o  = addr_q;
                    memwdata_o = merged;
                    state_d    = S_DRESP;
                end
                default: state_d = S_IDLE;
            endcase

            // A new accept overrides the return to idle (RMW never accepts).
            if (fetch_win) begin
                ireq_ready_o = 1'b1;
                memread_o    = 1'b1;
                memaddr_o    = i_word_addr;
                state_d      = S_IRESP;
            end else if (data_win) begin
                dreq_ready_o = 1'b1;
                state_d      = S_DRESP;
                if (!d_err) begin
                    memaddr_o = d_word_addr;
                    if (!dreq_we_i) begin
                        memread_o = 1'b1;
                    end else if (dreq_size_i == SIZE_W) begin
                        memwrite_o = 1'b1;
                        memwdata_o = dreq_wdata_i;
                    end else begin
                        memread_o = 1'b1;
                        state_d   = S_RMW;
                    end
                end
            end
        end
    end

    // State, grant history and capture of the accepted data request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_DATA;
            size_q       <= SIZE_B;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            is_load_q    <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (fetch_win) begin
                last_grant_q <= GRANT_FETCH;
            end else if (data_win) begin
                last_grant_q <= GRANT_DATA;
                size_q       <= dreq_size_i;
                off_q        <= dreq_addr_i[1:0];
                uns_q        <= dreq_unsigned_i;
                is_load_q    <= !dreq_we_i;
                err_q        <= d_err;
                addr_q       <= d_word_addr;
                wdata_q      <= dreq_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered one-cycle-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid, ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        dreq_valid, dreq_ready, dreq_we, dreq_unsigned;
    logic [1:0]  dreq_size;
    logic [31:0] dreq_addr, dreq_wdata;
    logic        dresp_valid, dresp_err;
    logic [31:0] dresp_rdata;
    logic        memread, memwrite;
    logic [31:0] memaddr, memwdata;
    logic [31:0] memrdata = 32'h0;

    logic [31:0] mem [0:15];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Read-only memory model: registered read of the word addressed last cycle.
    always @(posedge clk) begin
        if (memread) memrdata <= mem[memaddr[5:2]];
    end

    mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .ireq_valid_i    (ireq_valid),
        .ireq_ready_o    (ireq_ready),
        .ireq_addr_i     (ireq_addr),
        .iresp_valid_o   (iresp_valid),
        .iresp_data_o    (iresp_data),
        .dreq_valid_i    (dreq_valid),
        .dreq_ready_o    (dreq_ready),
        .dreq_we_i       (dreq_we),
        .dreq_size_i     (dreq_size),
        .dreq_unsigned_i (dreq_unsigned),
        .dreq_addr_i     (dreq_addr),
        .dreq_wdata_i    (dreq_wdata),
        .dresp_valid_o   (dresp_valid),
        .dresp_rdata_o   (dresp_rdata),
        .dresp_err_o     (dresp_err),
        .memread_o       (memread),
        .memwrite_o      (memwrite),
        .memaddr_o       (memaddr),
        .memwdata_o      (memwdata),
        .memrdata_i      (memrdata)
    );

    task automatic clear_inputs();
        ireq_valid = 0; ireq_addr = 0;
        dreq_valid = 0; dreq_we = 0; dreq_size = 2'b10; dreq_unsigned = 0;
        dreq_addr = 0; dreq_wdata = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_dreq(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        dreq_valid = 1; dreq_we = we; dreq_size = size; dreq_unsigned = uns;
        dreq_addr = addr; dreq_wdata = wdata;
    endtask

    task automatic test_reset();
        rst = 1; ireq_valid = 1; ireq_addr = 32'h4;
        set_dreq(0, 2'b10, 0, 32'h1000, 0);
        @(negedge clk);
        tests++; if (ireq_ready !== 1'b0 || dreq_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got i=%b d=%b want 0/0", ireq_ready, dreq_ready);
        end
        tests++; if (memread !== 1'b0 || memwrite !== 1'b0 || memaddr !== 32'h0) begin
            fails++; $display("FAIL reset_strobe: got rd=%b wr=%b a=%h want 0", memread, memwrite, memaddr);
        end
        step(); rst = 0; clear_inputs();
        @(negedge clk);
        tests++; if (iresp_valid !== 1'b0 || dresp_valid !== 1'b0 || memread !== 1'b0 ||
                     memaddr !== 32'h0 || dresp_rdata !== 32'h0) begin
            fails++; $display("FAIL post_reset_idle: got iv=%b dv=%b rd=%b a=%h want all 0",
                              iresp_valid, dresp_valid, memread, memaddr);
        end
        step();
    endtask

    task automatic test_fetch();
        mem[1] = 32'h12345678;
        ireq_valid = 1; ireq_addr = 32'h4;
        @(negedge clk);
        tests++; if (ireq_ready !== 1'b1 || memread !== 1'b1 || memaddr !== 32'h4) begin
            fails++; $display("FAIL fetch_req: got rdy=%b rd=%b a=%h want 1 1 00000004",
                              ireq_ready, memread, memaddr);
        end
        step(); ireq_valid = 0;
        @(negedge clk);
        tests++; if (iresp_valid !== 1'b1 || iresp_data !== 32'h12345678) begin
            fails++; $display("FAIL fetch_resp: got v=%b d=%h want 1 12345678", iresp_valid, iresp_data);
        end
        step();
        @(negedge clk);
        tests++; if (iresp_valid !== 1'b0) begin
            fails++; $display("FAIL fetch_pulse: got v=%b want 0", iresp_valid);
        end
        step();
    endtask

    task automatic test_back_to_back_loads();
        mem[0] = 32'h80FF00AA;
        set_dreq(0, 2'b00, 0, 32'h1003, 0);
        @(negedge clk);
        tests++; if (dreq_ready !== 1'b1 || memread !== 1'b1 || memaddr !== 32'h1000) begin
            fails++; $display("FAIL lb_req: got rdy=%b rd=%b a=%h want 1 1 00001000",
                              dreq_ready, memread, memaddr);
        end
        step(); dreq_unsigned = 1;
        @(negedge clk);
        tests++; if (dresp_valid !== 1'b1 || dresp_rdata !== 32'hFFFFFF80 || dresp_err !== 1'b0) begin
            fails++; $display("FAIL lb_signed: got v=%b d=%h e=%b want 1 ffffff80 0",
                              dresp_valid, dresp_rdata, dresp_err);
        end
        tests++; if (dreq_ready !== 1'b1 || memread !== 1'b1) begin
            fails++; $display("FAIL lbu_overlap_accept: got rdy=%b rd=%b want 1 1", dreq_ready, memread);
        end
        step(); clear_inputs();
        @(negedge clk);
        tests++; if (dresp_valid !== 1'b1 || dresp_rdata !== 32'h00000080) begin
            fails++; $display("FAIL lbu_unsigned: got v=%b d=%h want 1 00000080", dresp_valid, dresp_rdata);
        end
        step();
    endtask

    task automatic test_store_half();
        mem[0] = 32'h11223344;
        set_dreq(1, 2'b01, 0, 32'h1002, 32'h0000BEEF);
        @(negedge clk);
        tests++; if (dreq_ready !== 1'b1 || memread !== 1'b1 || memwrite !== 1'b0 ||
                     memaddr !== 32'h1000) begin
            fails++; $display("FAIL sh_read: got rdy=%b rd=%b wr=%b a=%h want 1 1 0 00001000",
                              dreq_ready, memread, memwrite, memaddr);
        end
        step(); clear_inputs(); ireq_valid = 1; ireq_addr = 32'h4;
        @(negedge clk);
        tests++; if (memwrite !== 1'b1 || memread !== 1'b0 || memwdata !== 32'hBEEF3344 ||
                     memaddr !== 32'h1000) begin
            fails++; $display("FAIL sh_write: got wr=%b rd=%b wd=%h a=%h want 1 0 beef3344 00001000",
                              memwrite, memread, memwdata, memaddr);
        end
        tests++; if (ireq_ready !== 1'b0 || dreq_ready !== 1'b0 || dresp_valid !== 1'b0) begin
            fails++; $display("FAIL sh_rmw_busy: got irdy=%b drdy=%b dv=%b want 0 0 0",
                              ireq_ready, dreq_ready, dresp_valid);
        end
        step(); clear_inputs();
        @(negedge clk);
        tests++; if (dresp_valid !== 1'b1 || dresp_rdata !== 32'h0 || dresp_err !== 1'b0 ||
                     memwrite !== 1'b0) begin
            fails++; $display("FAIL sh_ack: got v=%b d=%h e=%b wr=%b want 1 0 0 0",
                              dresp_valid, dresp_rdata, dresp_err, memwrite);
        end
        step();
    endtask

    task automatic test_tie();
        logic exp_f;
        rst = 1; step(); rst = 0;
        mem[0] = 32'hCAFEF00D; mem[1] = 32'h12345678;
        ireq_valid = 1; ireq_addr = 32'h4;
        set_dreq(0, 2'b10, 0, 32'h1000, 0);
        for (int i = 0; i < 4; i++) begin
            exp_f = (i % 2 == 0);
            @(negedge clk);
            tests++; if (ireq_ready !== exp_f || dreq_ready !== !exp_f ||
                         memaddr !== (exp_f ? 32'h4 : 32'h1000)) begin
                fails++; $display("FAIL tie_grant%0d: got i=%b d=%b a=%h want i=%b", i,
                                  ireq_ready, dreq_ready, memaddr, exp_f);
            end
            if (i > 0) begin
                tests++; if (exp_f ? (dresp_valid !== 1'b1 || dresp_rdata !== 32'hCAFEF00D)
                                   : (iresp_valid !== 1'b1 || iresp_data !== 32'h12345678)) begin
                    fails++; $display("FAIL tie_resp%0d: got iv=%b id=%h dv=%b dd=%h", i,
                                      iresp_valid, iresp_data, dresp_valid, dresp_rdata);
                end
            end
            step();
        end
        clear_inputs();
        @(negedge clk);
        tests++; if (dresp_valid !== 1'b1 || dresp_rdata !== 32'hCAFEF00D || iresp_valid !== 1'b0) begin
            fails++; $display("FAIL tie_last_resp: got dv=%b dd=%h iv=%b want 1 cafef00d 0",
                              dresp_valid, dresp_rdata, iresp_valid);
        end
        step();
    endtask

    task automatic test_errors();
        logic        we_v   [2] = '{1'b0, 1'b1};
        logic [1:0]  size_v [2] = '{2'b10, 2'b00};
        logic [31:0] addr_v [2] = '{32'h1001, 32'hFFF0};
        for (int i = 0; i < 2; i++) begin
            set_dreq(we_v[i], size_v[i], 0, addr_v[i], 32'hA5A5A5A5);
            @(negedge clk);
            tests++; if (dreq_ready !== 1'b1 || memread !== 1'b0 || memwrite !== 1'b0) begin
                fails++; $display("FAIL err%0d_nostrobe: got rdy=%b rd=%b wr=%b want 1 0 0", i,
                                  dreq_ready, memread, memwrite);
            end
            step(); clear_inputs();
            @(negedge clk);
            tests++; if (dresp_valid !== 1'b1 || dresp_err !== 1'b1 || dresp_rdata !== 32'h0) begin
                fails++; $display("FAIL err%0d_resp: got v=%b e=%b d=%h want 1 1 0", i,
                                  dresp_valid, dresp_err, dresp_rdata);
            end
            step();
        end
    endtask

    task automatic test_reset_in_rmw();
        mem[0] = 32'h11223344;
        set_dreq(1, 2'b00, 0, 32'h1001, 32'h00000055);
        @(negedge clk);
        tests++; if (memread !== 1'b1 || memwrite !== 1'b0) begin
            fails++; $display("FAIL rmw_rst_read: got rd=%b wr=%b want 1 0", memread, memwrite);
        end
        step(); clear_inputs(); rst = 1;
        @(negedge clk);
        tests++; if (memwrite !== 1'b0 || memread !== 1'b0 || memaddr !== 32'h0 ||
                     memwdata !== 32'h0 || dresp_valid !== 1'b0) begin
            fails++; $display("FAIL rmw_rst_quiet: got wr=%b rd=%b a=%h wd=%h dv=%b want all 0",
                              memwrite, memread, memaddr, memwdata, dresp_valid);
        end
        step(); rst = 0;
        ireq_valid = 1; ireq_addr = 32'h4;
        set_dreq(0, 2'b10, 0, 32'h1000, 0);
        @(negedge clk);
        tests++; if (ireq_ready !== 1'b1 || dreq_ready !== 1'b0 || dresp_valid !== 1'b0) begin
            fails++; $display("FAIL rmw_rst_tie: got i=%b d=%b dv=%b want 1 0 0",
                              ireq_ready, dreq_ready, dresp_valid);
        end
        step(); clear_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        clear_inputs();
        rst = 1;
        step(); step();
        test_reset();
        test_fetch();
        test_back_to_back_loads();
        test_store_half();
        test_tie();
        test_errors();
        test_reset_in_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
